// File: rtl/bch_gf_pkg.sv
// Shared GF(2^m) definitions for the BCH datapath: primitive polynomials,
// multiplier FSM states and single-step shift/reduce helpers.
package bch_gf_pkg;

    localparam int GF_MAX_M = 32;

    // Primitive polynomials with the x^m term dropped.
    localparam logic [3:0]  GF_POLY_M4  = 4'h3;
    localparam logic [4:0]  GF_POLY_M5  = 5'h05;
    localparam logic [5:0]  GF_POLY_M6  = 6'h03;
    localparam logic [6:0]  GF_POLY_M7  = 7'h03;
    localparam logic [7:0]  GF_POLY_M8  = 8'h1D;
    localparam logic [8:0]  GF_POLY_M9  = 9'h011;
    localparam logic [9:0]  GF_POLY_M10 = 10'h009;
    localparam logic [10:0] GF_POLY_M11 = 11'h005;
    localparam logic [11:0] GF_POLY_M12 = 12'h053;
    localparam logic [12:0] GF_POLY_M13 = 13'h001B;
    localparam logic [13:0] GF_POLY_M14 = 14'h0443;
    localparam logic [14:0] GF_POLY_M15 = 15'h0003;
    localparam logic [15:0] GF_POLY_M16 = 16'h100B;
    localparam logic [16:0] GF_POLY_M17 = 17'h00009;
    localparam logic [17:0] GF_POLY_M18 = 18'h00081;
    localparam logic [18:0] GF_POLY_M19 = 19'h00027;
    localparam logic [19:0] GF_POLY_M20 = 20'h00009;
    localparam logic [20:0] GF_POLY_M21 = 21'h000005;
    localparam logic [21:0] GF_POLY_M22 = 22'h000003;
    localparam logic [22:0] GF_POLY_M23 = 23'h000021;
    localparam logic [23:0] GF_POLY_M24 = 24'h000087;
    localparam logic [24:0] GF_POLY_M25 = 25'h0000009;
    localparam logic [25:0] GF_POLY_M26 = 26'h0000047;
    localparam logic [26:0] GF_POLY_M27 = 27'h0000027;
    localparam logic [27:0] GF_POLY_M28 = 28'h0000009;
    localparam logic [28:0] GF_POLY_M29 = 29'h00000005;
    localparam logic [29:0] GF_POLY_M30 = 30'h00800007;
    localparam logic [30:0] GF_POLY_M31 = 31'h00000009;

    typedef enum logic {IDLE, RUN} gf_state_e;

    function automatic int gf_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Multiply by x in a field of degree m held in the low m bits of v.
    function automatic logic [GF_MAX_M-1:0] gf_mulx(input logic [GF_MAX_M-1:0] v,
                                                    input logic [GF_MAX_M-1:0] poly,
                                                    input int m);
        logic [GF_MAX_M-1:0] mask;
        logic [GF_MAX_M-1:0] top;
        logic [GF_MAX_M-1:0] r;
        mask = (GF_MAX_M'(1) << m) - GF_MAX_M'(1);
        top  = v >> (m - 1);
        r    = (v << 1) & mask;
        if (top[0]) r = r ^ poly;
        return r;
    endfunction

endpackage

// File: rtl/bch_gf_digit_step.sv
// One digit step of the MSB-first multiplier: acc' = acc*x^D + a*d (mod p),
// evaluated Horner-style over the D digit bits.
module bch_gf_digit_step
    import bch_gf_pkg::*;
#(
    parameter int               C_M         = 31,
    parameter logic [C_M-1:0]   C_POLY_PRIM = 31'h00000009,
    parameter int               C_DIGIT     = 1
) (
    input  logic [C_M-1:0]      acc,
    input  logic [C_M-1:0]      a,
    input  logic [C_DIGIT-1:0]  digit,
    output logic [C_M-1:0]      acc_nxt
);

    always_comb begin
        logic [GF_MAX_M-1:0] t;
        logic [GF_MAX_M-1:0] a_x;
        logic [GF_MAX_M-1:0] p_x;
        t   = '0;
        a_x = '0;
        p_x = '0;
        t[C_M-1:0]   = acc;
        a_x[C_M-1:0] = a;
        p_x[C_M-1:0] = C_POLY_PRIM;
        for (int i = C_DIGIT - 1; i >= 0; i--) begin
            t = gf_mulx(t, p_x, C_M);
            if (digit[i]) t = t ^ a_x;
        end
        acc_nxt = t[C_M-1:0];
    end

endmodule

// File: rtl/bch_gf_mul_digit.sv
// Digit-serial GF(2^m) multiplier with valid/ready handshake and held result.
// Define BCH_GF_MUL_BYPASS_EN to finish trivial operands (0 or 1) in one cycle.
module bch_gf_mul_digit
    import bch_gf_pkg::*;
#(
    parameter int               C_M         = 31,
    parameter logic [C_M-1:0]   C_POLY_PRIM = 31'h00000009,
    parameter int               C_DIGIT     = 1
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic [C_M-1:0]  I_Multiplicant,
    input  logic [C_M-1:0]  I_Multiplier,
    input  logic            I_Mult_v,
    output logic            O_Ready,
    output logic [C_M-1:0]  O_Prod,
    output logic            O_Prod_v
);

    localparam int C_N  = gf_ceil_div(C_M, C_DIGIT);
    localparam int C_W  = C_N * C_DIGIT;
    localparam int C_CW = $clog2(C_N + 1);

    gf_state_e          state;
    logic [C_CW-1:0]    cnt;
    logic [C_M-1:0]     acc;
    logic [C_M-1:0]     acc_nxt;
    logic [C_M-1:0]     a_r;
    logic [C_W-1:0]     b_r;

    bch_gf_digit_step #(
        .C_M         (C_M),
        .C_POLY_PRIM (C_POLY_PRIM),
        .C_DIGIT     (C_DIGIT)
    ) u_step (
        .acc     (acc),
        .a       (a_r),
        .digit   (b_r[C_W-1 -: C_DIGIT]),
        .acc_nxt (acc_nxt)
    );

`ifdef BCH_GF_MUL_BYPASS_EN
    logic           byp;
    logic [C_M-1:0] byp_val;

    always_comb begin
        byp     = 1'b1;
        byp_val = '0;
        if (I_Multiplicant == '0 || I_Multiplier == '0)
            byp_val = '0;
        else if (I_Multiplicant == C_M'(1))
            byp_val = I_Multiplier;
        else if (I_Multiplier == C_M'(1))
            byp_val = I_Multiplicant;
        else
            byp = 1'b0;
    end
`endif

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state    <= IDLE;
            O_Ready  <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            O_Prod   <= '0;
            O_Prod_v <= 1'b0;
        end else begin
            O_Prod_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_Mult_v && O_Ready) begin
                        a_r <= I_Multiplicant;
                        // Zero padding at the MSB end gives leading zero digits.
                        b_r <= C_W'(I_Multiplier);
                        acc <= '0;
                        cnt <= '0;
`ifdef BCH_GF_MUL_BYPASS_EN
                        if (byp) begin
                            O_Prod   <= byp_val;
                            O_Prod_v <= 1'b1;
                        end else begin
                            state   <= RUN;
                            O_Ready <= 1'b0;
                        end
`else
                        state   <= RUN;
                        O_Ready <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    b_r <= b_r << C_DIGIT;
                    cnt <= cnt + 1'b1;
                    if (cnt == C_CW'(C_N - 1)) begin
                        O_Prod   <= acc_nxt;
                        O_Prod_v <= 1'b1;
                        state    <= IDLE;
                        O_Ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_gf_mul_digit.sv
// Bench for bch_gf_mul_digit: six field/digit configurations side by side,
// checked every cycle against a polynomial-arithmetic reference with timing.
module tb_bch_gf_mul_digit;

    localparam int NI = 6;

`ifdef BCH_GF_MUL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic int cm_of(input int g);
        return (g < 3) ? 4 : 31;
    endfunction

    function automatic int cd_of(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 1;
            4: return 4;
            default: return 31;
        endcase
    endfunction

    function automatic int poly_of(input int g);
        return (g < 3) ? 3 : 9;
    endfunction

    function automatic int nsteps(input int g);
        return (cm_of(g) + cd_of(g) - 1) / cd_of(g);
    endfunction

    function automatic logic [30:0] msk(input int g);
        return (31'd1 << cm_of(g)) - 31'd1;
    endfunction

    // Schoolbook carry-less product followed by long division by x^m + poly.
    function automatic logic [30:0] ref_mul(input logic [30:0] a, input logic [30:0] b,
                                            input int m, input logic [30:0] poly);
        logic [63:0] p;
        logic [63:0] fp;
        p = '0;
        for (int i = 0; i < m; i++)
            if (b[i]) p = p ^ (64'(a) << i);
        fp = (64'd1 << m) | 64'(poly);
        for (int i = 2 * m - 2; i >= m; i--)
            if (p[i]) p = p ^ (fp << (i - m));
        return p[30:0];
    endfunction

    logic        clk;
    logic        rst;
    logic [30:0] a_in   [NI];
    logic [30:0] b_in   [NI];
    logic        v_in   [NI];
    logic        rdy_o  [NI];
    logic        pv_o   [NI];
    logic [30:0] prod_o [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int M = cm_of(g);
        localparam int D = cd_of(g);
        localparam logic [M-1:0] P = M'(poly_of(g));
        logic [M-1:0] pw;
        logic         rdy;
        logic         pv;
        bch_gf_mul_digit #(
            .C_M         (M),
            .C_POLY_PRIM (P),
            .C_DIGIT     (D)
        ) u_dut (
            .I_clk          (clk),
            .I_rst          (rst),
            .I_Multiplicant (a_in[g][M-1:0]),
            .I_Multiplier   (b_in[g][M-1:0]),
            .I_Mult_v       (v_in[g]),
            .O_Ready        (rdy),
            .O_Prod         (pw),
            .O_Prod_v       (pv)
        );
        assign prod_o[g] = 31'(pw);
        assign rdy_o[g]  = rdy;
        assign pv_o[g]   = pv;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference timing: an accepted op completes N edges later; trivial
    // operands finish on the next edge when the bypass is built in.
    int          m_cnt  [NI];
    logic        m_rdy  [NI];
    logic        m_v    [NI];
    logic [30:0] m_prod [NI];
    logic [30:0] m_res  [NI];

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                m_cnt[g]  <= 0;
                m_rdy[g]  <= 1'b1;
                m_v[g]    <= 1'b0;
                m_prod[g] <= '0;
            end else begin
                m_v[g] <= 1'b0;
                if (m_cnt[g] > 0) begin
                    m_cnt[g] <= m_cnt[g] - 1;
                    if (m_cnt[g] == 1) begin
                        m_prod[g] <= m_res[g];
                        m_v[g]    <= 1'b1;
                        m_rdy[g]  <= 1'b1;
                    end
                end else if (v_in[g] && m_rdy[g]) begin
                    logic [30:0] a, b, r;
                    a = a_in[g] & msk(g);
                    b = b_in[g] & msk(g);
                    r = ref_mul(a, b, cm_of(g), 31'(poly_of(g)));
                    if (BYP && (a == 0 || b == 0 || a == 1 || b == 1)) begin
                        m_prod[g] <= r;
                        m_v[g]    <= 1'b1;
                    end else begin
                        m_res[g] <= r;
                        m_cnt[g] <= nsteps(g);
                        m_rdy[g] <= 1'b0;
                    end
                end
            end
        end
    end

    // Hand-computed results expected on the next O_Prod_v of an instance.
    logic [30:0] lit_tab [NI][8];
    int          lit_wr  [NI];
    bit          done;

    int tests;
    int fails;

    task automatic chk(input string nm, input int g, input logic [30:0] act, input logic [30:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, g, $time, act, exp);
        end
    endtask

    initial begin
        int lit_rd [NI];
        tests = 0;
        fails = 0;
        for (int g = 0; g < NI; g++) lit_rd[g] = 0;
        chk("ref_2x8_m4",   0, ref_mul(31'h2, 31'h8, 4, 31'h3), 31'h3);
        chk("ref_FxF_m4",   0, ref_mul(31'hF, 31'hF, 4, 31'h3), 31'hA);
        chk("ref_7x9_m4",   0, ref_mul(31'h7, 31'h9, 4, 31'h3), 31'hA);
        chk("ref_5x6_m4",   0, ref_mul(31'h5, 31'h6, 4, 31'h3), 31'hD);
        chk("ref_x30xx_m31", 3, ref_mul(31'h40000000, 31'h2, 31, 31'h9), 31'h9);
        chk("ref_3x7_m31",  3, ref_mul(31'h3, 31'h7, 31, 31'h9), 31'h9);
        while (!done) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                chk("ready", g, 31'(rdy_o[g]), 31'(m_rdy[g]));
                chk("prod_v", g, 31'(pv_o[g]), 31'(m_v[g]));
                chk("prod", g, prod_o[g], m_prod[g]);
                if (pv_o[g] && lit_rd[g] < lit_wr[g]) begin
                    chk("lit_prod", g, prod_o[g], lit_tab[g][lit_rd[g]]);
                    lit_rd[g]++;
                end
            end
        end
        for (int g = 0; g < NI; g++)
            chk("lit_results_seen", g, 31'(lit_rd[g]), 31'(lit_wr[g]));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_lit(input int g, input logic [30:0] exp);
        lit_tab[g][lit_wr[g]] = exp;
        lit_wr[g]++;
    endtask

    task automatic issue1(input int g, input logic [30:0] a, input logic [30:0] b, input logic [30:0] exp);
        push_lit(g, exp);
        a_in[g] = a;
        b_in[g] = b;
        v_in[g] = 1'b1;
        cyc(1);
        v_in[g] = 1'b0;
    endtask

    task automatic issue_m31(input logic [30:0] a, input logic [30:0] b, input logic [30:0] exp);
        for (int g = 3; g < NI; g++) begin
            push_lit(g, exp);
            a_in[g] = a;
            b_in[g] = b;
            v_in[g] = 1'b1;
        end
        cyc(1);
        for (int g = 3; g < NI; g++) v_in[g] = 1'b0;
        cyc(34);
    endtask

    function automatic logic [30:0] rnd31();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 31'h0;
        if (sel == 1) return 31'h1;
        return 31'($urandom());
    endfunction

    initial begin
        done = 1'b0;
        rst  = 1'b1;
        for (int g = 0; g < NI; g++) begin
            a_in[g] = '0;
            b_in[g] = '0;
            v_in[g] = 1'b0;
            lit_wr[g] = 0;
        end
        cyc(3);
        rst = 1'b0;
        cyc(2);

        issue1(0, 31'h2, 31'h8, 31'h3);
        cyc(6);
        issue1(1, 31'hF, 31'hF, 31'hA);
        issue1(2, 31'h7, 31'h9, 31'hA);
        cyc(5);

        // Valid held high with fresh operands every cycle, including during RUN.
        for (int k = 0; k < 40; k++) begin
            for (int g = 0; g < 3; g++) begin
                a_in[g] = 31'($urandom_range(0, 15));
                b_in[g] = 31'($urandom_range(0, 15));
                v_in[g] = 1'b1;
            end
            cyc(1);
        end
        for (int g = 0; g < 3; g++) v_in[g] = 1'b0;
        cyc(6);

        // Abort a 4-step op after two steps, then rerun cleanly.
        a_in[0] = 31'h5;
        b_in[0] = 31'h6;
        v_in[0] = 1'b1;
        cyc(1);
        v_in[0] = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        issue1(0, 31'h5, 31'h6, 31'hD);
        cyc(6);

        issue_m31(31'h3, 31'h7, 31'h9);
        issue_m31(31'h0, 31'h1234567, 31'h0);
        issue_m31(31'h5A5A5A5A, 31'h1, 31'h5A5A5A5A);
        issue_m31(31'h1, 31'h2468ACE, 31'h2468ACE);
        issue_m31(31'h40000000, 31'h2, 31'h9);

        for (int k = 0; k < 40000; k++) begin
            for (int g = 3; g < NI; g++) begin
                a_in[g] = rnd31();
                b_in[g] = rnd31();
                v_in[g] = ($urandom_range(0, 7) != 0);
            end
            cyc(1);
        end
        for (int g = 3; g < NI; g++) v_in[g] = 1'b0;
        cyc(40);
        done = 1'b1;
    end

endmodule
